// File: rtl/seq_chunk_adder_pkg.sv
// seq_chunk_adder_pkg: shared FSM state encoding and the counter-width
// helper for the multi-cycle chunked adder/subtractor.
package seq_chunk_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Width of the slice counter; never below one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_chunk_adder_if.sv
// seq_chunk_adder_if: operation bundle for seq_chunk_adder.
// master (controller): drives start/sub/a/b/cin and reads busy/done/sum/cout/ovf.
// slave (adder): the reverse direction.
interface seq_chunk_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/seq_chunk_adder_rca_slice.sv
// rca_slice: combinational CHUNK-bit ripple carry adder built from full-adder cells.
// Ports: a, b (CHUNK), cin -> sum (CHUNK), cout.
module rca_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);
    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[CHUNK];
endmodule

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: WIDTH-bit add/subtract, CHUNK bits per clock through one
// shared ripple slice with a registered carry; start/busy/done handshake.
// Ports: clk, rst (sync, active high), bus (slave modport: start, sub, a, b,
// cin in; busy, done, sum, cout, ovf out).
module seq_chunk_adder
    import seq_chunk_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                clk,
    input  logic                rst,
    seq_chunk_adder_if.slave    bus
);
    localparam int NSLICE = WIDTH / CHUNK;
    localparam int CW     = cnt_width(NSLICE);
    localparam int MSB    = WIDTH - 1;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK-1:0] slice_a;
    logic [CHUNK-1:0] slice_b;
    logic [CHUNK-1:0] slice_sum;
    logic             slice_cout;
    logic             last;
    int               slice_idx;

    // b_q holds the effective operand (already inverted for subtract).
    assign slice_idx = int'(cnt_q) * CHUNK;
    assign slice_a   = a_q[slice_idx +: CHUNK];
    assign slice_b   = b_q[slice_idx +: CHUNK];
    assign last      = (cnt_q == CW'(NSLICE - 1));

    rca_slice #(
        .CHUNK (CHUNK)
    ) u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub ? 1'b1 : bus.cin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                res_d[slice_idx +: CHUNK] = slice_sum;
                carry_d = slice_cout;
                // Counter wraps to 0 after the last slice so the slice
                // select never points outside the operand.
                cnt_d   = last ? '0 : cnt_q + CW'(1);
                if (last) begin
                    state_d = ST_DONE;
                    sum_d   = res_d;
                    cout_d  = slice_cout;
                    ovf_d   = (a_q[MSB] == b_q[MSB]) && (res_d[MSB] != a_q[MSB]);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy = (state_q == ST_RUN);
    assign bus.done = (state_q == ST_DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb_seq_chunk_adder: scoreboard bench for seq_chunk_adder at 16/4, 8/8 and 8/1.
// Drivers push expected results; negedge monitors pop and compare on done.
module tb_seq_chunk_adder;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    exp_t q16[$];
    exp_t q8a[$];
    exp_t q8b[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_chunk_adder_if #(.WIDTH(16)) if16 ();
    seq_chunk_adder_if #(.WIDTH(8))  if8a ();
    seq_chunk_adder_if #(.WIDTH(8))  if8b ();

    logic       s8_start = 1'b0;
    logic       s8_sub = 1'b0;
    logic [7:0] s8_a = '0;
    logic [7:0] s8_b = '0;
    logic       s8_cin = 1'b0;

    assign if8a.start = s8_start;
    assign if8a.sub   = s8_sub;
    assign if8a.a     = s8_a;
    assign if8a.b     = s8_b;
    assign if8a.cin   = s8_cin;
    assign if8b.start = s8_start;
    assign if8b.sub   = s8_sub;
    assign if8b.a     = s8_a;
    assign if8b.b     = s8_b;
    assign if8b.cin   = s8_cin;

    seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u16 (
        .clk (clk), .rst (rst), .bus (if16.slave)
    );
    seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) u8a (
        .clk (clk), .rst (rst), .bus (if8a.slave)
    );
    seq_chunk_adder #(.WIDTH(8), .CHUNK(1)) u8b (
        .clk (clk), .rst (rst), .bus (if8b.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    // Issue one 16-bit op; returns at the negedge after the accept edge.
    task automatic op16(input logic s, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic [15:0] es, input logic ec,
                        input logic eo, input bit push);
        int n = 0;
        while (if16.busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) bound_fail("wait16");
        if16.sub   = s;
        if16.a     = a;
        if16.b     = b;
        if16.cin   = ci;
        if16.start = 1'b1;
        if (push) q16.push_back('{es, ec, eo, cyc + 1 + 4});
        @(negedge clk);
        if16.start = 1'b0;
    endtask

    // Issue one op to both 8-bit instances; expected values from a plain model.
    task automatic op8(input logic s, input logic [7:0] a, input logic [7:0] b,
                       input logic ci);
        int         n = 0;
        logic [8:0] r;
        logic [7:0] eb;
        logic       co;
        logic       ov;
        while ((if8a.busy || if8b.busy) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) bound_fail("wait8");
        if (s) begin
            r  = {1'b0, a} - {1'b0, b};
            co = ~r[8];
            ov = (a[7] != b[7]) && (r[7] != a[7]);
        end else begin
            r  = {1'b0, a} + {1'b0, b} + {8'd0, ci};
            co = r[8];
            ov = (a[7] == b[7]) && (r[7] != a[7]);
        end
        eb = r[7:0];
        s8_sub   = s;
        s8_a     = a;
        s8_b     = b;
        s8_cin   = ci;
        s8_start = 1'b1;
        q8a.push_back('{{8'd0, eb}, co, ov, cyc + 1 + 1});
        q8b.push_back('{{8'd0, eb}, co, ov, cyc + 1 + 8});
        @(negedge clk);
        s8_start = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && if16.done) begin
            if (q16.size() == 0) begin
                bound_fail("done16_unexpected");
            end else begin
                e = q16.pop_front();
                chk("sum16", 32'(if16.sum), 32'(e.sum));
                chk("cout16", 32'(if16.cout), 32'(e.cout));
                chk("ovf16", 32'(if16.ovf), 32'(e.ovf));
                chk("lat16", 32'(cyc), 32'(e.cyc));
                chk("busy16_at_done", 32'(if16.busy), 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && if8a.done) begin
            if (q8a.size() == 0) begin
                bound_fail("done8a_unexpected");
            end else begin
                e = q8a.pop_front();
                chk("sum8a", 32'(if8a.sum), 32'(e.sum));
                chk("cout8a", 32'(if8a.cout), 32'(e.cout));
                chk("ovf8a", 32'(if8a.ovf), 32'(e.ovf));
                chk("lat8a", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && if8b.done) begin
            if (q8b.size() == 0) begin
                bound_fail("done8b_unexpected");
            end else begin
                e = q8b.pop_front();
                chk("sum8b", 32'(if8b.sum), 32'(e.sum));
                chk("cout8b", 32'(if8b.cout), 32'(e.cout));
                chk("ovf8b", 32'(if8b.ovf), 32'(e.ovf));
                chk("lat8b", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        int n;
        if16.start = 1'b0;
        if16.sub   = 1'b0;
        if16.a     = '0;
        if16.b     = '0;
        if16.cin   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst_busy", 32'(if16.busy), 32'd0);
        chk("rst_done", 32'(if16.done), 32'd0);
        chk("rst_sum", 32'(if16.sum), 32'd0);
        chk("rst_cout", 32'(if16.cout), 32'd0);
        chk("rst_ovf", 32'(if16.ovf), 32'd0);
        @(negedge clk);

        // Zero op: busy for exactly four cycles, then done with busy low.
        op16(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1);
        for (int i = 0; i < 4; i++) begin
            chk("busy_run", 32'(if16.busy), 32'd1);
            chk("done_run", 32'(if16.done), 32'd0);
            @(negedge clk);
        end
        chk("busy_done_cycle", 32'(if16.busy), 32'd0);
        chk("done_pulse", 32'(if16.done), 32'd1);
        @(negedge clk);
        chk("done_one_cycle", 32'(if16.done), 32'd0);

        op16(1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1);
        op16(1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1);
        op16(1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1);
        op16(1'b1, 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0, 1);
        op16(1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1);

        // Start during RUN with new operands must be ignored.
        op16(1'b0, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1);
        if16.start = 1'b1;
        if16.sub   = 1'b1;
        if16.a     = 16'hFFFF;
        if16.b     = 16'hFFFF;
        @(negedge clk);
        chk("sum_stable_busy", 32'(if16.sum), 32'h7FFF);
        @(negedge clk);
        if16.start = 1'b0;

        op16(1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1);

        // Abort: reset in the second RUN cycle, no done expected.
        op16(1'b0, 16'h0F0F, 16'h0101, 1'b0, 16'h0000, 1'b0, 1'b0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(if16.busy), 32'd0);
        chk("abort_done", 32'(if16.done), 32'd0);
        chk("abort_sum", 32'(if16.sum), 32'd0);
        chk("abort_cout", 32'(if16.cout), 32'd0);
        chk("abort_ovf", 32'(if16.ovf), 32'd0);
        repeat (6) @(negedge clk);

        op16(1'b0, 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 1);

        // Sweep instances: directed corners then random operands.
        op8(1'b0, 8'hFF, 8'h01, 1'b0);
        op8(1'b0, 8'h7F, 8'h00, 1'b1);
        op8(1'b1, 8'h80, 8'h01, 1'b0);
        op8(1'b1, 8'h03, 8'h09, 1'b1);
        for (int i = 0; i < 12; i++) begin
            op8(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                1'($urandom_range(0, 1)));
        end

        n = 0;
        while ((q16.size() != 0 || q8a.size() != 0 || q8b.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) bound_fail("drain");
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
